// File: rtl/decode_pkg.sv
// decode_pkg
//   Shared definitions for the instruction decode stage: datapath widths,
//   opcode encodings, the decoded bundle presented to execute, the
//   decode FSM state type and immediate sign-extension helpers.
package decode_pkg;

  localparam int DEC_PC_W    = 12;
  localparam int DEC_INSTR_W = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef struct packed {
    logic                valid;
    logic [3:0]          opcode;
    logic [3:0]          rd;
    logic [3:0]          rs1;
    logic [3:0]          rs2;
    logic [15:0]         imm;
    logic [DEC_PC_W-1:0] pc;
  } decoded_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } dec_state_t;

  function automatic logic [15:0] sext4(input logic [3:0] v);
    return {{12{v[3]}}, v};
  endfunction

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/decode_fields.sv
// decode_fields
//   Purely combinational field extraction for one instruction word.
//   fields.valid is set only for opcodes that execute acts on
//   (ALU, memory, branch). NOP, JMP and HALT are defined but produce no
//   bundle; anything else raises illegal. Unused fields are driven to 0
//   and fields.pc is always 0 (the caller supplies the word address).
// Ports
//   instruction  in   16-bit instruction word
//   fields       out  decoded_t bundle (pc = 0)
//   illegal      out  opcode is undefined
module decode_fields
  import decode_pkg::*;
(
  input  logic [DEC_INSTR_W-1:0] instruction,
  output decoded_t               fields,
  output logic                   illegal
);

  logic [3:0] op;

  assign op = instruction[15:12];

  always_comb begin
    fields        = '0;
    illegal       = 1'b0;
    fields.opcode = op;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        fields.valid = 1'b1;
        fields.rd    = instruction[11:8];
        fields.rs1   = instruction[7:4];
        fields.rs2   = instruction[3:0];
      end
      OP_ADDI: begin
        fields.valid = 1'b1;
        fields.rd    = instruction[11:8];
        fields.imm   = sext8(instruction[7:0]);
      end
      OP_LD: begin
        fields.valid = 1'b1;
        fields.rd    = instruction[11:8];
        fields.rs1   = instruction[7:4];
        fields.imm   = sext4(instruction[3:0]);
      end
      OP_ST: begin
        // store data register sits in the rd slot of the encoding
        fields.valid = 1'b1;
        fields.rs2   = instruction[11:8];
        fields.rs1   = instruction[7:4];
        fields.imm   = sext4(instruction[3:0]);
      end
      OP_BEQ: begin
        fields.valid = 1'b1;
        fields.rs1   = instruction[11:8];
        fields.rs2   = instruction[7:4];
        fields.imm   = sext4(instruction[3:0]);
      end
      OP_NOP, OP_JMP, OP_HALT: begin
        fields.valid = 1'b0;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_unit.sv
// decode_unit
//   Decode stage behind the 16-bit fetch stage. Drives the fetch
//   advance/redirect controls, resolves JMP and HALT locally, squashes
//   the stale word fetched on every redirect, and registers a decoded
//   bundle for execute with stall/flush handshake.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   RUN   | fetching and decoding normally
//   HALT  | HALT decoded; fetch frozen until flush_in (or reset)
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   instruction         registered word from fetch
//   en_pc               fetch advance (load mem[pc], pc+1)
//   en_new_pc, new_pc   fetch redirect and its target
//   stall_in            execute not ready; hold the bundle
//   flush_in, flush_pc  execute-resolved taken branch and its target
//   d_*                 registered decoded bundle
//   illegal             one-cycle pulse on an undefined opcode
//   halted              FSM is in HALT
module decode_unit
  import decode_pkg::*;
#(
  parameter int PC_W    = DEC_PC_W,
  parameter int INSTR_W = DEC_INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruction,
  output logic               en_pc,
  output logic               en_new_pc,
  output logic [PC_W-1:0]    new_pc,
  input  logic               stall_in,
  input  logic               flush_in,
  input  logic [PC_W-1:0]    flush_pc,
  output logic               d_valid,
  output logic [3:0]         d_opcode,
  output logic [3:0]         d_rd,
  output logic [3:0]         d_rs1,
  output logic [3:0]         d_rs2,
  output logic [15:0]        d_imm,
  output logic [PC_W-1:0]    d_pc,
  output logic               illegal,
  output logic               halted
);

  dec_state_t      state_q, state_d;
  logic [PC_W-1:0] shadow_pc_q, shadow_pc_d;
  logic [PC_W-1:0] word_pc_q, word_pc_d;
  logic            word_valid_q, word_valid_d;
  decoded_t        bundle_q, bundle_d;
  logic            illegal_q, illegal_d;

  decoded_t        fields;
  logic            fields_illegal;
  logic [3:0]      opcode;
  logic            run;

  assign opcode = instruction[INSTR_W-1:INSTR_W-4];
  assign run    = (state_q == RUN);

  decode_fields u_fields (
    .instruction (instruction),
    .fields      (fields),
    .illegal     (fields_illegal)
  );

  // Fetch control. A held HALT word must not advance fetch, otherwise the
  // word after HALT would be loaded before the FSM leaves RUN.
  always_comb begin
    en_pc     = 1'b0;
    en_new_pc = 1'b0;
    new_pc    = '0;
    if (flush_in) begin
      en_new_pc = 1'b1;
      new_pc    = flush_pc;
    end else if (run && word_valid_q && !stall_in && opcode == OP_JMP) begin
      en_new_pc = 1'b1;
      new_pc    = instruction[PC_W-1:0];
    end else begin
      en_pc = run && !stall_in && !(word_valid_q && opcode == OP_HALT);
    end
  end

  // Mirror of the fetch pc so each word carries its own address.
  always_comb begin
    shadow_pc_d  = shadow_pc_q;
    word_pc_d    = word_pc_q;
    word_valid_d = word_valid_q;
    if (en_new_pc) begin
      shadow_pc_d  = new_pc;
      word_valid_d = 1'b0;
    end else if (en_pc) begin
      word_pc_d    = shadow_pc_q;
      shadow_pc_d  = shadow_pc_q + 1'b1;
      word_valid_d = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    bundle_d  = bundle_q;
    illegal_d = 1'b0;
    if (flush_in) begin
      bundle_d.valid = 1'b0;
      state_d        = RUN;
    end else if (stall_in) begin
      bundle_d = bundle_q;
    end else if (word_valid_q && run) begin
      if (fields_illegal) begin
        bundle_d.valid = 1'b0;
        illegal_d      = 1'b1;
      end else if (fields.valid) begin
        bundle_d    = fields;
        bundle_d.pc = word_pc_q;
      end else begin
        bundle_d.valid = 1'b0;
        if (opcode == OP_HALT) begin
          state_d = HALT;
        end
      end
    end else begin
      bundle_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      shadow_pc_q  <= '0;
      word_pc_q    <= '0;
      word_valid_q <= 1'b0;
      bundle_q     <= '0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_pc_q  <= shadow_pc_d;
      word_pc_q    <= word_pc_d;
      word_valid_q <= word_valid_d;
      bundle_q     <= bundle_d;
      illegal_q    <= illegal_d;
    end
  end

  assign d_valid  = bundle_q.valid;
  assign d_opcode = bundle_q.opcode;
  assign d_rd     = bundle_q.rd;
  assign d_rs1    = bundle_q.rs1;
  assign d_rs2    = bundle_q.rs2;
  assign d_imm    = bundle_q.imm;
  assign d_pc     = bundle_q.pc;
  assign illegal  = illegal_q;
  assign halted   = (state_q == HALT);

endmodule
